// File: rtl/core_types_pkg.sv
// Shared types for the physical-register free list and its checkpoints.
// Defines the depth constants, the wrap-bit pointer and the column index.
package core_types_pkg;

  localparam int FREE_LIST_DEPTH = 32;
  localparam int LOG_FREE_LIST_DEPTH = $clog2(FREE_LIST_DEPTH);
  localparam int CHECKPOINT_COLUMNS = 4;
  localparam int LOG_CHECKPOINT_COLUMNS = $clog2(CHECKPOINT_COLUMNS);

  typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;
  typedef logic [LOG_FREE_LIST_DEPTH:0] free_list_ptr_t;

endpackage

// File: rtl/ckpt_ptr_table.sv
// Checkpoint table of saved free-list head pointers.
// Ports: clk, rst, one write port (wr_en/wr_col/wr_ptr), one read port (rd_col/rd_ptr).
module ckpt_ptr_table
  import core_types_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  checkpoint_column_t wr_col,
  input  free_list_ptr_t     wr_ptr,
  input  checkpoint_column_t rd_col,
  output free_list_ptr_t     rd_ptr
);

  free_list_ptr_t tbl [CHECKPOINT_COLUMNS];

  // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd_ptr = tbl[rd_col];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
        tbl[i] <= '0;
      end
    end else if (wr_en) begin
      tbl[wr_col] <= wr_ptr;
    end
  end

endmodule

// File: rtl/phys_reg_free_list_ckpt.sv
// Circular free list of physical register tags with checkpointed head pointer.
// Ports: CLK/RST, dequeue, enqueue, save/restore, revert, free_count, error_flag.
module phys_reg_free_list_ckpt #(
  parameter int NUM_PHYS_REGS      = 64,
  parameter int NUM_ARCH_REGS      = 32,
  parameter int CHECKPOINT_COLUMNS = 4
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic                                         dequeue_valid,
  output logic                                         dequeue_ready,
  output logic [$clog2(NUM_PHYS_REGS)-1:0]             dequeue_phys_reg_tag,
  input  logic                                         enqueue_valid,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0]             enqueue_phys_reg_tag,
  input  logic                                         save_valid,
  input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0]        save_column,
  input  logic                                         restore_valid,
  input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0]        restore_column,
  input  logic                                         revert_valid,
  output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0] free_count,
  output logic                                         error_flag
);

  import core_types_pkg::*;

  localparam int TAG_W = $clog2(NUM_PHYS_REGS);
  localparam free_list_ptr_t DEPTH_PTR = free_list_ptr_t'(FREE_LIST_DEPTH);

  typedef logic [TAG_W-1:0] tag_t;

  tag_t           mem [FREE_LIST_DEPTH];
  free_list_ptr_t head;
  free_list_ptr_t tail;
  free_list_ptr_t head_nxt;
  free_list_ptr_t tail_nxt;
  free_list_ptr_t cnt;
  free_list_ptr_t new_cnt;
  free_list_ptr_t saved_ptr;
  logic           err;
  logic           err_nxt;
  logic           deq_fire;
  logic           enq_fire;
  logic           full;
  logic           empty;

  ckpt_ptr_table u_ckpt (
    .clk    (CLK),
    .rst    (RST),
    .wr_en  (save_valid),
    .wr_col (save_column),
    .wr_ptr (head_nxt),
    .rd_col (restore_column),
    .rd_ptr (saved_ptr)
  );

  always_comb begin
    cnt      = tail - head;
    full     = (cnt == DEPTH_PTR);
    empty    = (cnt == '0);
    head_nxt = head;
    err_nxt  = 1'b0;
    deq_fire = 1'b0;
    if (restore_valid) begin
      head_nxt = saved_ptr;
    end else if (revert_valid) begin
      if (full) err_nxt = 1'b1;
      else      head_nxt = head - 1'b1;
    end else if (dequeue_valid) begin
      if (empty) begin
        err_nxt = 1'b1;
      end else begin
        head_nxt = head + 1'b1;
        deq_fire = 1'b1;
      end
    end
    // A full list only has room when a slot is freed at the head this cycle.
    enq_fire = enqueue_valid && (!full || deq_fire);
    if (enqueue_valid && !enq_fire) err_nxt = 1'b1;
    tail_nxt = enq_fire ? tail + 1'b1 : tail;
    new_cnt  = tail_nxt - head_nxt;
    if (restore_valid && (new_cnt > DEPTH_PTR)) err_nxt = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head <= '0;
      tail <= DEPTH_PTR;
      err  <= 1'b0;
      for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
        mem[i] <= tag_t'(NUM_ARCH_REGS + i);
      end
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      err  <= err | err_nxt;
      if (enq_fire) mem[tail[LOG_FREE_LIST_DEPTH-1:0]] <= enqueue_phys_reg_tag;
    end
  end

  assign dequeue_ready        = !empty;
  assign dequeue_phys_reg_tag = mem[head[LOG_FREE_LIST_DEPTH-1:0]];
  assign free_count           = cnt;
  assign error_flag           = err;

endmodule

// File: tb/tb_phys_reg_free_list_ckpt.sv
// Self-checking bench for phys_reg_free_list_ckpt.
// Unbounded-integer queue model plus directed literal checks.
module tb_phys_reg_free_list_ckpt;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       dequeue_valid = 1'b0;
  logic       dequeue_ready;
  logic [5:0] dequeue_phys_reg_tag;
  logic       enqueue_valid = 1'b0;
  logic [5:0] enqueue_phys_reg_tag = '0;
  logic       save_valid = 1'b0;
  logic [1:0] save_column = '0;
  logic       restore_valid = 1'b0;
  logic [1:0] restore_column = '0;
  logic       revert_valid = 1'b0;
  logic [5:0] free_count;
  logic       error_flag;

  int n_cmp = 0;
  int n_bad = 0;

  phys_reg_free_list_ckpt dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .dequeue_valid        (dequeue_valid),
    .dequeue_ready        (dequeue_ready),
    .dequeue_phys_reg_tag (dequeue_phys_reg_tag),
    .enqueue_valid        (enqueue_valid),
    .enqueue_phys_reg_tag (enqueue_phys_reg_tag),
    .save_valid           (save_valid),
    .save_column          (save_column),
    .restore_valid        (restore_valid),
    .restore_column       (restore_column),
    .revert_valid         (revert_valid),
    .free_count           (free_count),
    .error_flag           (error_flag)
  );

  always #5 CLK = ~CLK;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: pointers are plain ever-growing integers; slots are index mod 32.
  int m_head, m_tail;
  int m_saved [4];
  int m_mem [32];
  bit m_err;
  bit m_valid = 1'b0;

  function automatic int slot(int p);
    return ((p % 32) + 32) % 32;
  endfunction

  always @(posedge CLK) begin : model
    int c, hd;
    bit dqd;
    if (RST) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32 + i;
      for (int i = 0; i < 4; i++) m_saved[i] = 0;
      m_head = 0;
      m_tail = 32;
      m_err = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      c = m_tail - m_head;
      hd = m_head;
      dqd = 1'b0;
      if (restore_valid) begin
        hd = m_saved[restore_column];
      end else if (revert_valid) begin
        if (c == 32) m_err = 1'b1;
        else hd = m_head - 1;
      end else if (dequeue_valid) begin
        if (c == 0) m_err = 1'b1;
        else begin
          hd = m_head + 1;
          dqd = 1'b1;
        end
      end
      if (enqueue_valid) begin
        if (c == 32 && !dqd) m_err = 1'b1;
        else begin
          m_mem[slot(m_tail)] = enqueue_phys_reg_tag;
          m_tail++;
        end
      end
      if (restore_valid && (m_tail - hd) > 32) m_err = 1'b1;
      if (save_valid) m_saved[save_column] = hd;
      m_head = hd;
    end
  end

  always @(negedge CLK) begin
    if (m_valid && !RST) begin
      check("m_ready", dequeue_ready, (m_tail != m_head));
      check("m_count", free_count, (m_tail - m_head) & 63);
      check("m_err", error_flag, m_err);
      if (m_tail != m_head)
        check("m_tag", dequeue_phys_reg_tag, m_mem[slot(m_head)]);
    end
  end

  task automatic idle();
    dequeue_valid = 1'b0;
    enqueue_valid = 1'b0;
    save_valid = 1'b0;
    restore_valid = 1'b0;
    revert_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic deq_n(int n);
    for (int i = 0; i < n; i++) begin
      dequeue_valid = 1'b1;
      tick();
    end
  endtask

  task automatic enq(int tag);
    enqueue_valid = 1'b1;
    enqueue_phys_reg_tag = 6'(tag);
    tick();
  endtask

  task automatic save(int col);
    save_valid = 1'b1;
    save_column = 2'(col);
    tick();
  endtask

  task automatic restore(int col);
    restore_valid = 1'b1;
    restore_column = 2'(col);
    tick();
  endtask

  initial begin
    idle();
    @(posedge CLK);
    #1;
    do_reset();

    // Reset state and drain the whole list.
    check("rst_ready", dequeue_ready, 1);
    check("rst_tag", dequeue_phys_reg_tag, 32);
    check("rst_count", free_count, 32);
    check("rst_err", error_flag, 0);
    for (int i = 0; i < 32; i++) begin
      check("drain_tag", dequeue_phys_reg_tag, 32 + i);
      deq_n(1);
    end
    check("drain_ready", dequeue_ready, 0);
    check("drain_count", free_count, 0);
    check("drain_err", error_flag, 0);

    // Empty: enqueue and dequeue together, no bypass.
    dequeue_valid = 1'b1;
    enq(7);
    check("empty_deq_err", error_flag, 1);
    check("empty_enq_tag", dequeue_phys_reg_tag, 7);
    check("empty_enq_count", free_count, 1);

    // Two dequeues then two reverts.
    do_reset();
    deq_n(2);
    check("rv_pre_tag", dequeue_phys_reg_tag, 34);
    revert_valid = 1'b1;
    tick();
    revert_valid = 1'b1;
    tick();
    check("rv_tag", dequeue_phys_reg_tag, 32);
    check("rv_count", free_count, 32);
    check("rv_err", error_flag, 0);
    revert_valid = 1'b1;
    tick();
    check("rv_full_err", error_flag, 1);
    check("rv_full_tag", dequeue_phys_reg_tag, 32);

    // Save at head 3, dequeue four, restore.
    do_reset();
    deq_n(3);
    save(2);
    for (int i = 0; i < 4; i++) begin
      check("ck_tag", dequeue_phys_reg_tag, 35 + i);
      deq_n(1);
    end
    restore(2);
    check("ck_rs_tag", dequeue_phys_reg_tag, 35);
    check("ck_rs_count", free_count, 29);
    check("ck_rs_err", error_flag, 0);

    // Full list enqueue alone is dropped.
    do_reset();
    enq(5);
    check("full_enq_err", error_flag, 1);
    check("full_enq_count", free_count, 32);
    check("full_enq_tag", dequeue_phys_reg_tag, 32);

    // Full list enqueue with dequeue is legal.
    do_reset();
    dequeue_valid = 1'b1;
    enq(5);
    check("fe_count", free_count, 32);
    check("fe_tag", dequeue_phys_reg_tag, 33);
    check("fe_err", error_flag, 0);
    deq_n(31);
    check("fe_wrap_tag", dequeue_phys_reg_tag, 5);
    check("fe_wrap_count", free_count, 1);

    // Restore + revert + dequeue + save on the same column.
    do_reset();
    deq_n(2);
    save(1);
    deq_n(2);
    dequeue_valid = 1'b1;
    revert_valid = 1'b1;
    save_valid = 1'b1;
    save_column = 2'd1;
    restore(1);
    check("pri_tag", dequeue_phys_reg_tag, 34);
    check("pri_count", free_count, 30);
    check("pri_err", error_flag, 0);
    deq_n(1);
    restore(1);
    check("pri_saved_tag", dequeue_phys_reg_tag, 34);

    // Restore that would exceed the depth.
    do_reset();
    save(0);
    deq_n(1);
    enq(9);
    check("ovr_pre_err", error_flag, 0);
    restore(0);
    check("ovr_err", error_flag, 1);
    check("ovr_count", free_count, 33);

    // Reset in the middle of traffic wins.
    do_reset();
    enq(3);
    deq_n(3);
    check("mid_pre_err", error_flag, 1);
    RST = 1'b1;
    dequeue_valid = 1'b1;
    enqueue_valid = 1'b1;
    revert_valid = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_tag", dequeue_phys_reg_tag, 32);
    check("mid_count", free_count, 32);
    check("mid_err", error_flag, 0);
    deq_n(1);
    check("mid_post_tag", dequeue_phys_reg_tag, 33);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list_ckpt.md
PHYS_REG_FREE_LIST_CKPT -- requirements
Module: phys_reg_free_list_ckpt

Interface
REQ-001 Parameter NUM_PHYS_REGS, 64, total physical registers.
REQ-002 Parameter NUM_ARCH_REGS, 32, architectural registers; DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS, a power of 2.
REQ-003 Parameter CHECKPOINT_COLUMNS, 4, number of saved head-pointer columns, a power of 2.
REQ-004 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 dequeue_valid  in  1  rename consumes the head tag this cycle.
REQ-007 dequeue_ready  out  1  free list non-empty (count != 0).
REQ-008 dequeue_phys_reg_tag  out  log2(NUM_PHYS_REGS)  tag at head, valid when dequeue_ready.
REQ-009 enqueue_valid  in  1  commit returns a freed tag.
REQ-010 enqueue_phys_reg_tag  in  log2(NUM_PHYS_REGS)  freed tag.
REQ-011 save_valid, save_column  in  1, log2(CHECKPOINT_COLUMNS)  store head pointer into column.
REQ-012 restore_valid, restore_column  in  1, log2(CHECKPOINT_COLUMNS)  reload head pointer from column.
REQ-013 revert_valid  in  1  undo one dequeue (ROB revert walk).
REQ-014 free_count  out  log2(DEPTH)+1  number of free tags.
REQ-015 error_flag  out  1  sticky illegal-operation indicator.

Function
REQ-016 Storage: DEPTH-entry circular array; head/tail pointers log2(DEPTH)+1 bits with a wrap bit; count = tail - head modulo 2^(log2(DEPTH)+1).
REQ-017 dequeue_phys_reg_tag is a combinational read of array[head]; no enqueue-to-dequeue bypass.
REQ-018 Head update priority per cycle: restore > revert > dequeue; lower-priority head requests that cycle are ignored without error.
REQ-019 Dequeue: dequeue_valid && dequeue_ready -> head+1 next edge; dequeue_valid while empty -> no change, error_flag set.
REQ-020 Revert: head-1 next edge, exposing the previously dequeued tag unchanged; revert when count == DEPTH -> ignored, error_flag set.
REQ-021 Restore: head <= saved[restore_column] next edge; tail unaffected, so tags freed since the save remain free.
REQ-022 Save: saved[save_column] <= head value after this cycle's head update (post-dequeue/revert); save and restore in the same cycle to the same column -> restore reads the old value.
REQ-023 Enqueue: array[tail] <= tag, tail+1, independent of head operations; enqueue when count == DEPTH and no head-decrementing-count operation that cycle -> write dropped, error_flag set.
REQ-024 Simultaneous enqueue and dequeue at count == DEPTH is legal; count stays DEPTH.
REQ-025 A restore yielding count > DEPTH sets error_flag; state still updates.
REQ-026 Pointer arithmetic wraps modulo 2^(log2(DEPTH)+1); entry index is the low log2(DEPTH) bits.
REQ-027 error_flag clears only on reset.

Reset
REQ-028 On RST: array[i] = NUM_ARCH_REGS + i for all i; head = 0; tail = DEPTH (wrap bit 1, index 0); all saved columns = 0; error_flag = 0.
REQ-029 Outputs in the first cycle after reset: dequeue_ready = 1, dequeue_phys_reg_tag = NUM_ARCH_REGS, free_count = DEPTH.
REQ-030 RST asserted mid-operation overrides all same-cycle requests.

Structure
REQ-031 core_types_pkg holds FREE_LIST_DEPTH, LOG_FREE_LIST_DEPTH, CHECKPOINT_COLUMNS, checkpoint_column_t, and a new free_list_ptr_t (LOG_FREE_LIST_DEPTH+1 bits).
REQ-032 One sub-module, ckpt_ptr_table: CHECKPOINT_COLUMNS x free_list_ptr_t register array with one write port and one read port.

Verification
REQ-033 Reset, then 32 back-to-back dequeues -> tags 32..63 in order, dequeue_ready=0 on cycle 33, free_count=0.
REQ-034 Save col 2 at head=3, dequeue 4 (tags 35..38), restore col 2 -> next tag 35, free_count=29.
REQ-035 Dequeue tags 32,33, then 2 reverts -> dequeue_phys_reg_tag=32, free_count=32, error_flag=0.
REQ-036 Empty list, enqueue tag 7 and dequeue same cycle -> dequeue ignored, error_flag=1; next cycle tag 7 presented.
REQ-037 Full list (reset), enqueue tag 5 alone -> dropped, error_flag=1; with simultaneous dequeue -> tag 32 out, count stays 32, tag 5 stored at tail.
REQ-038 Restore, revert and dequeue asserted together -> only restore applied; save same column same cycle -> restore uses the old pointer.
